// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - decode/EX/writeback side signals of the pipeline interlock controller
interface hazard_ctrl_if #(
  parameter int REG_ADDR_LEN = 5,
  parameter int CNT_W        = 16
);
  logic                    id_valid;
  logic [REG_ADDR_LEN-1:0] id_rs1_addr;
  logic                    id_rs1_en;
  logic [REG_ADDR_LEN-1:0] id_rs2_addr;
  logic                    id_rs2_en;
  logic [REG_ADDR_LEN-1:0] id_wr_addr;
  logic                    id_wr_en;
  logic                    id_is_halt;
  logic                    br_taken;
  logic                    wb_valid;
  logic [REG_ADDR_LEN-1:0] wb_addr;
  logic                    IsStall;
  logic                    IsFlush;
  logic                    issue;
  logic                    halted;
  logic                    sb_err;
  logic [CNT_W-1:0]        stall_cnt;

  modport master (
    output id_valid, id_rs1_addr, id_rs1_en, id_rs2_addr, id_rs2_en,
           id_wr_addr, id_wr_en, id_is_halt, br_taken, wb_valid, wb_addr,
    input  IsStall, IsFlush, issue, halted, sb_err, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs1_en, id_rs2_addr, id_rs2_en,
           id_wr_addr, id_wr_en, id_is_halt, br_taken, wb_valid, wb_addr,
    output IsStall, IsFlush, issue, halted, sb_err, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - in-order interlock: pending-write scoreboard, branch flush and HALT drain
module hazard_ctrl #(
  parameter int REG_ADDR_LEN = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  bus
);
  localparam int         DEPTH      = 2 ** REG_ADDR_LEN;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALTED} state_t;

  state_t           state;
  logic [3:0]       flush_cnt;
  logic [DEPTH-1:0] pend;
  logic             is_flush_q;
  logic             halted_q;
  logic             sb_err_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic hazard;
  logic stall;
  logic issue;
  logic set_en;
  logic clr_en;

  // pend[0] is never set, so address-0 compares fall out false on their own.
  always_comb begin
    hazard = bus.id_valid &
             ((bus.id_rs1_en & pend[bus.id_rs1_addr]) |
              (bus.id_rs2_en & pend[bus.id_rs2_addr]) |
              (bus.id_wr_en  & pend[bus.id_wr_addr]));
    stall  = 1'b0;
    issue  = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          stall = hazard & ~bus.br_taken;
          issue = bus.id_valid & ~hazard & ~bus.br_taken;
        end
        DRAIN, HALTED: stall = 1'b1;
        default: ;
      endcase
    end
    set_en = issue & bus.id_wr_en & (bus.id_wr_addr != '0);
    clr_en = bus.wb_valid & (bus.wb_addr != '0);
  end

  // The set is written after the clear so a same-register collision resolves to set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend     <= '0;
      sb_err_q <= 1'b0;
    end else begin
      if (clr_en) begin
        pend[bus.wb_addr] <= 1'b0;
        if (!pend[bus.wb_addr]) sb_err_q <= 1'b1;
      end
      if (set_en) pend[bus.id_wr_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if ((state == RUN) && stall && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      flush_cnt  <= '0;
      is_flush_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.br_taken) begin
            state      <= FLUSH;
            flush_cnt  <= FLUSH_LOAD;
            is_flush_q <= 1'b1;
          end else if (issue && bus.id_is_halt) begin
            state <= DRAIN;
          end
        end
        FLUSH: begin
          if (bus.br_taken) begin
            flush_cnt <= FLUSH_LOAD;
          end else if (flush_cnt <= 4'd1) begin
            state      <= RUN;
            flush_cnt  <= '0;
            is_flush_q <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        DRAIN: begin
          // A taken branch means the HALT was wrong-path; it beats the empty test.
          if (bus.br_taken) begin
            state      <= FLUSH;
            flush_cnt  <= FLUSH_LOAD;
            is_flush_q <= 1'b1;
          end else if (pend == '0) begin
            state    <= HALTED;
            halted_q <= 1'b1;
          end
        end
        default: begin
          state    <= HALTED;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.IsStall   = stall;
  assign bus.issue     = issue;
  assign bus.IsFlush   = is_flush_q;
  assign bus.halted    = halted_q;
  assign bus.sb_err    = sb_err_q;
  assign bus.stall_cnt = stall_cnt_q;
endmodule
